// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status flags and the
// handshake FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SHL = 4'd2,
        OP_SHR = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_ASR = 4'd8,
        OP_ROL = 4'd9,
        OP_CMP = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_flags_if.sv
// Request/result handshake bundle between the operand sequencer, the ALU
// and the result consumer.
interface alu_seq_flags_if #(
    parameter int WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_carry, out_zero, out_neg, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result,
        output out_carry, out_zero, out_neg, out_ovf, out_err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier; one partial product per cycle,
// the last one is folded into the combinational product on the done cycle.
module alu_mul_seq #(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic               busy;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign done    = busy && (cnt == '0);
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= SHW'(WIDTH - 1);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                acc    <= product;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq_flags.sv
// Clocked ALU with status flags, valid/ready on both sides and a
// multi-cycle multiply; results sit in one output register.
module alu_seq_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input logic            clk,
    input logic            rst_n,
    alu_seq_flags_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_e state_q, state_d;
    logic   ready;
    logic   start;
    logic   load_alu;
    logic   load_mul;
    logic   mul_done;

    logic [2*WIDTH-1:0] product;
    logic               valid_q;
    logic [WIDTH-1:0]   res_q;
    flags_t             flags_q;

    logic [WIDTH:0]   sum, dif, shl, shr, asr;
    logic [WIDTH-1:0] a, b, rot, rol, res, fval;
    flags_t           fl, mul_fl;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        start    = 1'b0;
        load_alu = 1'b0;
        load_mul = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = !valid_q || bus.out_ready;
                if (bus.in_valid && ready) begin
                    if (bus.in_op == OP_MUL) begin
                        start   = 1'b1;
                        state_d = MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Shifts carry one spare bit so the last bit shifted out lands there.
    always_comb begin
        a    = bus.in_a;
        b    = bus.in_b;
        sum  = {1'b0, a} + {1'b0, b};
        dif  = {1'b0, a} - {1'b0, b};
        shl  = {1'b0, a} << b;
        shr  = {a, 1'b0} >> b;
        asr  = $signed({a, 1'b0}) >>> b;
        rot  = b % WIDTH'(WIDTH);
        rol  = (a << rot) | (a >> (WIDTH'(WIDTH) - rot));
        res  = '0;
        fl   = '0;
        case (bus.in_op)
            OP_ADD: begin
                res      = sum[MSB:0];
                fl.carry = sum[WIDTH];
                fl.ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res      = (bus.in_op == OP_CMP) ? a : dif[MSB:0];
                fl.carry = dif[WIDTH];
                fl.ovf   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            OP_SHL: begin
                res      = shl[MSB:0];
                fl.carry = shl[WIDTH];
            end
            OP_SHR: begin
                res      = shr[WIDTH:1];
                fl.carry = shr[0];
            end
            OP_ASR: begin
                res      = asr[WIDTH:1];
                fl.carry = asr[0];
            end
            OP_ROL: begin
                res      = rol;
                fl.carry = (rot != '0) && rol[0];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_MUL: res = '0;
            default: fl.err = 1'b1;
        endcase
        fval    = (bus.in_op == OP_CMP) ? dif[MSB:0] : res;
        fl.zero = (fval == '0);
        fl.neg  = fval[MSB];
    end

    always_comb begin
        mul_fl      = '0;
        mul_fl.zero = (product[MSB:0] == '0);
        mul_fl.neg  = product[MSB];
        mul_fl.ovf  = |product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (load_alu) begin
            valid_q <= 1'b1;
            res_q   <= res;
            flags_q <= fl;
        end else if (load_mul) begin
            valid_q <= 1'b1;
            res_q   <= product[MSB:0];
            flags_q <= mul_fl;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.out_carry  = flags_q.carry;
    assign bus.out_zero   = flags_q.zero;
    assign bus.out_neg    = flags_q.neg;
    assign bus.out_ovf    = flags_q.ovf;
    assign bus.out_err    = flags_q.err;
endmodule
